// File: rtl/hex_bin_reader.sv
`default_nettype none
// ============================================================================
// Module : hex_bin_reader
// Decodes binary 0/1 patterns on N active-low 7-segment digits and reports
// each stable value once over valid/ready; flags undecodable digits.
// Optional: define SEG_BLANK_EN to accept a blank digit as 0.
// Rev    : 1.0
// ============================================================================
module hex_bin_reader #(
  parameter int N_DIGITS      = 5,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [6:0]          i_bin_HEXs [N_DIGITS-1:0],
  output logic [N_DIGITS-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_err,
  output logic [N_DIGITS-1:0] o_err_mask
);

  localparam int              CW        = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   STABLE    = STABLE_CYCLES[CW-1:0];
  localparam int              SW        = 7 * N_DIGITS;
  localparam logic [6:0]      SEG_ZERO  = 7'b1000000;
  localparam logic [6:0]      SEG_ONE   = 7'b1111001;
`ifdef SEG_BLANK_EN
  localparam logic [6:0]      SEG_BLANK = 7'b1111111;
`endif

  localparam logic [1:0] S_SETTLE      = 2'd0;
  localparam logic [1:0] S_PRESENT     = 2'd1;
  localparam logic [1:0] S_WAIT_CHANGE = 2'd2;

  logic [1:0]          state, state_next;
  logic [SW-1:0]       sample, prev_sample, last_pat;
  logic [CW-1:0]       cnt, stable_next;
  logic [N_DIGITS-1:0] dec_bits, illegal;
  logic                changed, settled, differs_last;
  logic                load_data, load_err, cnt_clr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sample      <= '0;
      prev_sample <= '0;
    end else begin
      for (int i = 0; i < N_DIGITS; i++) begin
        sample[i*7 +: 7] <= i_bin_HEXs[i];
      end
      prev_sample <= sample;
    end
  end

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_dec
    logic [6:0] seg;
    assign seg         = sample[i*7 +: 7];
    assign dec_bits[i] = (seg == SEG_ONE);
`ifdef SEG_BLANK_EN
    assign illegal[i]  = !((seg == SEG_ONE) || (seg == SEG_ZERO) || (seg == SEG_BLANK));
`else
    assign illegal[i]  = !((seg == SEG_ONE) || (seg == SEG_ZERO));
`endif
  end

  // settled looks at the counter's next value so a report lands on the edge
  // where the count reaches STABLE_CYCLES, not one cycle later
  assign changed      = (sample != prev_sample);
  assign stable_next  = changed ? '0 : ((cnt == STABLE) ? cnt : cnt + 1'b1);
  assign settled      = (stable_next == STABLE);
  assign differs_last = (sample != last_pat);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt <= '0;
    else       cnt <= cnt_clr ? '0 : stable_next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_SETTLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_SETTLE:      if (settled) state_next = (|illegal) ? S_WAIT_CHANGE : S_PRESENT;
      S_PRESENT:     if (i_ready) state_next = differs_last ? S_SETTLE : S_WAIT_CHANGE;
      S_WAIT_CHANGE: if (differs_last) state_next = S_SETTLE;
      default:       state_next = S_SETTLE;
    endcase
  end

  always_comb begin
    o_valid   = 1'b0;
    load_data = 1'b0;
    load_err  = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      S_SETTLE: begin
        load_data = settled && !(|illegal);
        load_err  = settled && (|illegal);
      end
      S_PRESENT: begin
        o_valid = 1'b1;
        cnt_clr = i_ready && differs_last;
      end
      S_WAIT_CHANGE: cnt_clr = differs_last;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data     <= '0;
      o_err      <= 1'b0;
      o_err_mask <= '0;
      last_pat   <= '0;
    end else begin
      o_err <= load_err;
      if (load_data)            o_data     <= dec_bits;
      if (load_err)             o_err_mask <= illegal;
      if (load_data || load_err) last_pat  <= sample;
    end
  end

endmodule
`default_nettype wire
